// File: rtl/uart_pkg.sv
// Shared definitions for the UART output path: byte width, arbiter state
// encoding and a ceil(log2) helper usable in parameter expressions.
package uart_pkg;

  localparam int ASCII_SIZE = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    SEND  = ST_SEND
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/uart_rr_select.sv
// Combinational round-robin picker: returns the first requester found
// searching upward (cyclically) from last_idx+1, as one-hot and as an index.
module uart_rr_select
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               found,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  int cand;
  logic [IDX_W-1:0] cand_idx;

  // last_idx < NUM_REQ and k <= NUM_REQ, so a single subtraction wraps the candidate
  always_comb begin
    found    = 1'b0;
    onehot   = '0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_idx) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found            = 1'b1;
        onehot[cand_idx] = 1'b1;
        idx              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX byte channel among NUM_REQ packet
// sources; one grant per packet, bytes paced against the transmitter idle flag.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ASCII_SIZE  = uart_pkg::ASCII_SIZE,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ASCII_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          pkt_abort,
  output logic                          tx_ready_in,
  output logic [ASCII_SIZE-1:0]         tx_data,
  input  logic                          tx_idle
);

  import uart_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int CNT_W = clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_LEN);

  arb_state_t              state;
  logic [IDX_W-1:0]        last_idx;
  logic [IDX_W-1:0]        grant_idx;
  logic [CNT_W-1:0]        byte_cnt;
  logic                    last_q;

  logic                    pick_found;
  logic [NUM_REQ-1:0]      pick_onehot;
  logic [IDX_W-1:0]        pick_idx;

  logic                    sel_valid;
  logic                    sel_last;
  logic [ASCII_SIZE-1:0]   sel_data;

  uart_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_select (
    .req      (req_valid),
    .last_idx (last_idx),
    .found    (pick_found),
    .onehot   (pick_onehot),
    .idx      (pick_idx)
  );

  assign sel_valid = |(req_valid & grant);
  assign sel_last  = |(req_last & grant);
  assign busy      = |grant;
  assign req_ready = (state == FETCH && tx_idle) ? grant : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_data = req_data[i*ASCII_SIZE +: ASCII_SIZE];
    end
  end

  // A byte is only taken while UART_TX is idle, and tx_ready_in is held until
  // the transmitter drops idle, so consecutive frames can never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      last_idx    <= IDX_W'(NUM_REQ - 1);
      byte_cnt    <= '0;
      last_q      <= 1'b0;
      tx_ready_in <= 1'b0;
      tx_data     <= '0;
      pkt_abort   <= 1'b0;
    end else begin
      pkt_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant     <= pick_onehot;
            grant_idx <= pick_idx;
            byte_cnt  <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (sel_valid && tx_idle) begin
            tx_data     <= sel_data;
            tx_ready_in <= 1'b1;
            last_q      <= sel_last;
            if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + CNT_W'(1);
            state       <= SEND;
          end
        end
        SEND: begin
          if (!tx_idle) begin
            tx_ready_in <= 1'b0;
            if (last_q) begin
              grant    <= '0;
              last_idx <= grant_idx;
              state    <= IDLE;
            end else if (byte_cnt == CNT_MAX) begin
              pkt_abort <= 1'b1;
              grant     <= '0;
              last_idx  <= grant_idx;
              state     <= IDLE;
            end else begin
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued packet sources, a UART_TX timing model and
// a byte scoreboard checking line order, grant behaviour and pacing.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ASCII_SIZE  = 8;
  localparam int MAX_PKT_LEN = 16;
  localparam int FRAME       = 8;

  logic                          clk;
  logic                          reset;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ASCII_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          pkt_abort;
  logic                          tx_ready_in;
  logic [ASCII_SIZE-1:0]         tx_data;
  logic                          tx_idle;

  logic [8:0]         src_q [NUM_REQ][$];
  logic [7:0]         exp_q [$];
  logic [NUM_REQ-1:0] src_hold;
  logic [NUM_REQ-1:0] fire_q;
  logic [8:0]         head;
  logic [7:0]         exp_b;
  logic               prev_ready;

  int errors      = 0;
  int checks      = 0;
  int cap_cnt     = 0;
  int overlap_cnt = 0;
  int rdy_viol    = 0;
  int frame_left  = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ASCII_SIZE  (ASCII_SIZE),
    .MAX_PKT_LEN (MAX_PKT_LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .busy        (busy),
    .pkt_abort   (pkt_abort),
    .tx_ready_in (tx_ready_in),
    .tx_data     (tx_data),
    .tx_idle     (tx_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Handshakes are sampled mid-cycle, where every DUT input and output is stable
  initial begin
    fire_q = '0;
    forever begin
      @(negedge clk);
      fire_q = req_valid & req_ready;
      if ((|req_ready) && !tx_idle) rdy_viol++;
    end
  end

  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire_q[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && !src_hold[i]) begin
          head = src_q[i][0];
          req_valid[i] = 1'b1;
          req_last[i]  = head[8];
          req_data[i*ASCII_SIZE +: ASCII_SIZE] = head[7:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
          req_data[i*ASCII_SIZE +: ASCII_SIZE] = 8'h00;
        end
      end
    end
  end

  // UART_TX model: takes a byte when idle and ready_in is high, then stays busy for a frame
  initial begin
    tx_idle    = 1'b1;
    prev_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_ready_in && !prev_ready && !tx_idle) overlap_cnt++;
      prev_ready = tx_ready_in;
      if (!tx_idle) begin
        frame_left--;
        if (frame_left == 0) tx_idle = 1'b1;
      end else if (tx_ready_in) begin
        cap_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL uart_byte: got %02h, required no byte", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("[TB] FAIL uart_byte: got %02h, required %02h", tx_data, exp_b);
          end
        end
        tx_idle    = 1'b0;
        frame_left = FRAME;
      end
    end
  end

  task automatic push_src(input int src, input logic [7:0] b, input logic last);
    src_q[src].push_back({last, b});
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic push_pkt(input int src, input string s);
    for (int i = 0; i < s.len(); i++) begin
      push_src(src, s[i], (i == s.len() - 1));
      push_exp(s[i]);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    bit empty;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      empty = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) empty = 1'b0;
      done = empty && (exp_q.size() == 0) && tx_idle && !busy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_drain: pending bytes=%0d busy=%0b, required 0/0 within budget",
               name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (grant !== '0)       begin errors++; $display("[TB] FAIL rst_grant: got %b, required 0000", grant); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (req_ready !== '0)   begin errors++; $display("[TB] FAIL rst_req_ready: got %b, required 0000", req_ready); end
    checks++; if (pkt_abort !== 1'b0) begin errors++; $display("[TB] FAIL rst_pkt_abort: got %b, required 0", pkt_abort); end
    checks++; if (tx_ready_in !== 1'b0) begin errors++; $display("[TB] FAIL rst_tx_ready_in: got %b, required 0", tx_ready_in); end
    checks++; if (tx_data !== 8'h00)  begin errors++; $display("[TB] FAIL rst_tx_data: got %02h, required 00", tx_data); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    push_pkt(0, "A"); push_pkt(1, "B"); push_pkt(2, "C"); push_pkt(3, "D");
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL rr_first_grant: got %b, required 0001", grant); end
    wait_drain("rr_abcd");
    push_pkt(1, "x");
    wait_drain("rr_setup");
    push_src(0, "A", 1'b1); push_src(1, "B", 1'b1); push_src(2, "C", 1'b1); push_src(3, "D", 1'b1);
    push_exp("C"); push_exp("D"); push_exp("A"); push_exp("B");
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL rr_rotated_grant: got %b, required 0100", grant); end
    wait_drain("rr_cdab");
  endtask

  task automatic test_single_ok();
    int  bad_grant;
    bit  seen_last;
    bad_grant = 0;
    seen_last = 1'b0;
    push_pkt(0, "OK\n");
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0001)     begin errors++; $display("[TB] FAIL ok_grant: got %b, required 0001", grant); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL ok_req_ready: got %b, required 0001", req_ready); end
    @(negedge clk);
    checks++; if (tx_ready_in !== 1'b1)  begin errors++; $display("[TB] FAIL ok_tx_ready_in: got %b, required 1", tx_ready_in); end
    checks++; if (tx_data !== 8'h4F)     begin errors++; $display("[TB] FAIL ok_tx_data: got %02h, required 4f", tx_data); end
    for (int n = 0; n < 500 && !seen_last; n++) begin
      @(negedge clk);
      if (busy && grant !== 4'b0001) bad_grant++;
      if (req_valid[0] && req_ready[0] && req_last[0]) seen_last = 1'b1;
    end
    checks++; if (!seen_last) begin errors++; $display("[TB] FAIL ok_last_fire: got none, required last byte transfer"); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ok_busy_send: got %b, required 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ok_busy_release: got %b, required 0", busy); end
    checks++; if (bad_grant != 0) begin errors++; $display("[TB] FAIL ok_grant_held: got %0d bad cycles, required 0", bad_grant); end
    wait_drain("ok");
  endtask

  task automatic test_back_to_back();
    int gap;
    bit seen_busy;
    bit done;
    gap = 0;
    seen_busy = 1'b0;
    done = 1'b0;
    push_pkt(0, "ab");
    push_pkt(0, "cd");
    for (int n = 0; n < 800 && !done; n++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      else if (seen_busy && src_q[0].size() > 0) gap++;
      done = seen_busy && !busy && (exp_q.size() == 0) && tx_idle;
    end
    checks++; if (gap != 1) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %0d cycles, required 1", gap); end
    checks++; if (rdy_viol != 0) begin errors++; $display("[TB] FAIL b2b_ready_while_busy: got %0d, required 0", rdy_viol); end
    wait_drain("b2b");
  endtask

  task automatic test_abort();
    int  start;
    bit  seen_abort;
    seen_abort = 1'b0;
    for (int i = 0; i < 20; i++) push_src(2, 8'h61 + 8'(i), (i == 19));
    for (int i = 0; i < 16; i++) push_exp(8'h61 + 8'(i));
    push_exp("Z");
    for (int i = 16; i < 20; i++) push_exp(8'h61 + 8'(i));
    start = cap_cnt;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL abort_grant: got %b, required 0100", grant); end
    push_src(3, "Z", 1'b1);
    for (int n = 0; n < 600 && !seen_abort; n++) begin
      @(negedge clk);
      if (pkt_abort) seen_abort = 1'b1;
    end
    checks++; if (!seen_abort) begin errors++; $display("[TB] FAIL abort_pulse: got none, required pulse"); end
    checks++; if (cap_cnt - start != MAX_PKT_LEN) begin errors++; $display("[TB] FAIL abort_count: got %0d bytes, required %0d", cap_cnt - start, MAX_PKT_LEN); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL abort_release: got %b, required 0000", grant); end
    @(negedge clk);
    checks++; if (pkt_abort !== 1'b0) begin errors++; $display("[TB] FAIL abort_width: got %b, required 0", pkt_abort); end
    checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL abort_next_grant: got %b, required 1000", grant); end
    wait_drain("abort");
  endtask

  task automatic test_drop_valid();
    int start;
    int bad_grant;
    bad_grant = 0;
    push_pkt(1, "1234");
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL drop_grant: got %b, required 0010", grant); end
    push_pkt(0, "pq");
    start = cap_cnt;
    for (int n = 0; n < 200 && (cap_cnt - start) < 2; n++) @(negedge clk);
    src_hold[1] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (grant !== 4'b0010) bad_grant++;
    end
    checks++; if (bad_grant != 0) begin errors++; $display("[TB] FAIL drop_grant_held: got %0d bad cycles, required 0", bad_grant); end
    checks++; if (cap_cnt - start != 2) begin errors++; $display("[TB] FAIL drop_stalled: got %0d bytes, required 2", cap_cnt - start); end
    src_hold[1] = 1'b0;
    wait_drain("drop");
  endtask

  task automatic test_reset_mid_packet();
    int start;
    push_src(0, "R", 1'b0); push_src(0, "S", 1'b0); push_src(0, "T", 1'b1);
    push_exp("R");
    start = cap_cnt;
    for (int n = 0; n < 200 && (cap_cnt - start) < 1; n++) @(negedge clk);
    checks++; if (tx_ready_in !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_send: got %b, required 1", tx_ready_in); end
    reset = 1'b0;
    #1;
    checks++; if (grant !== '0)         begin errors++; $display("[TB] FAIL mid_rst_grant: got %b, required 0000", grant); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("[TB] FAIL mid_rst_busy: got %b, required 0", busy); end
    checks++; if (tx_ready_in !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_tx_ready_in: got %b, required 0", tx_ready_in); end
    checks++; if (tx_data !== 8'h00)    begin errors++; $display("[TB] FAIL mid_rst_tx_data: got %02h, required 00", tx_data); end
    src_q[0].delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_pkt(2, "N");
    wait_drain("mid_reset");
    checks++; if (overlap_cnt != 0) begin errors++; $display("[TB] FAIL mid_overlap: got %0d, required 0", overlap_cnt); end
    checks++; if (rdy_viol != 0)    begin errors++; $display("[TB] FAIL mid_ready_while_busy: got %0d, required 0", rdy_viol); end
  endtask

  initial begin
    src_hold = '0;
    reset    = 1'b0;
    $display("[TB] uart_tx_arbiter bench start");
    test_reset();
    test_round_robin();
    test_single_ok();
    test_back_to_back();
    test_abort();
    test_drop_valid();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
